// File: rtl/micro_udp_engine_pkg.sv
// Shared constants and FSM state type for the micro UDP engine ARP paths.
package micro_udp_engine_pkg;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [47:0] ETH_BCAST        = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  ARP_HLEN_ETH     = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4    = 8'h04;

    // A 60-byte frame occupies two 32-byte beats, leaving 4 unused bytes on the last one.
    localparam logic [4:0]  ARP_REQ_LAST_EMPTY = 5'd4;

    typedef enum logic [2:0] {
        ARP_REQ_IDLE,
        ARP_REQ_TX0,
        ARP_REQ_TX1,
        ARP_REQ_WAIT,
        ARP_REQ_DONE
    } arp_req_state_e;

endpackage

// File: rtl/micro_udp_engine_arp_req_frame.sv
// Combinational builder for a broadcast ARP "who-has" frame, split into two 256-bit beats.
// First frame byte lands on bits [255:248] of beat 0.
module micro_udp_engine_arp_req_frame
    import micro_udp_engine_pkg::*;
#(
    parameter logic [47:0] CONFIG_MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter logic [31:0] CONFIG_IP_ADDR  = 32'h0A00_0001
) (
    input  logic [31:0]  i_targetIpv4,
    input  logic         i_beat,
    output logic [255:0] o_data
);

    logic [511:0] w_frame;

    // Bytes 0..63 of the padded frame, byte 0 in the most significant position.
    assign w_frame = {
        ETH_BCAST,
        CONFIG_MAC_ADDR,
        ETHERTYPE_ARP,
        ARP_HTYPE_ETH,
        ARP_PTYPE_IPV4,
        ARP_HLEN_ETH,
        ARP_PLEN_IPV4,
        ARP_OPER_REQUEST,
        CONFIG_MAC_ADDR,
        CONFIG_IP_ADDR,
        48'h0,
        i_targetIpv4,
        176'h0
    };

    assign o_data = i_beat ? w_frame[255:0] : w_frame[511:256];

endmodule

// File: rtl/micro_udp_engine_arp_req.sv
// ARP request initiator: sends a broadcast who-has frame, waits for a matching ARP-table
// insert, retries on timeout and reports the resolved MAC or a failure.
module micro_udp_engine_arp_req
    import micro_udp_engine_pkg::*;
#(
    parameter logic [47:0] CONFIG_MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter logic [31:0] CONFIG_IP_ADDR  = 32'h0A00_0001,
    parameter int          TIMEOUT_CYCLES  = 1_000_000,
    parameter int          MAX_RETRIES     = 3
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_ipv4,

    input  logic         arp_table_insert,
    input  logic [47:0]  arp_table_mac,
    input  logic [31:0]  arp_table_ipv4,

    output logic [255:0] arp_req_tx_data,
    output logic [4:0]   arp_req_tx_empty,
    output logic         arp_req_tx_startofpacket,
    output logic         arp_req_tx_endofpacket,
    output logic         arp_req_tx_valid,
    input  logic         arp_req_tx_ready,

    output logic         resolve_done,
    output logic         resolve_ok,
    output logic [47:0]  resolve_mac,
    output logic [31:0]  resolve_ipv4
);

    localparam int TIMER_W   = $clog2(TIMEOUT_CYCLES);
    localparam int ATTEMPT_W = $clog2(MAX_RETRIES + 2);

    localparam logic [TIMER_W-1:0]   TIMER_LOAD    = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ATTEMPT_W-1:0] ATTEMPT_LIMIT = ATTEMPT_W'(MAX_RETRIES + 1);

    arp_req_state_e         r_state;
    logic [31:0]            r_targetIpv4;
    logic                   r_hit;
    logic [47:0]            r_hitMac;
    logic [TIMER_W-1:0]     r_timer;
    logic [ATTEMPT_W-1:0]   r_attempts;

    logic [255:0]           r_txData;
    logic [4:0]             r_txEmpty;
    logic                   r_txSop;
    logic                   r_txEop;
    logic                   r_txValid;

    logic                   r_resolveDone;
    logic                   r_resolveOk;
    logic [47:0]            r_resolveMac;
    logic [31:0]            r_resolveIpv4;

    logic                   w_reqFire;
    logic                   w_beatFire;
    logic                   w_match;
    logic                   w_hitNow;
    logic [47:0]            w_hitMacNow;
    logic [31:0]            w_buildIpv4;
    logic                   w_buildBeat;
    logic [255:0]           w_beatData;

    assign req_ready   = (r_state == ARP_REQ_IDLE) && !reset;
    assign w_reqFire   = req_valid && req_ready;
    assign w_beatFire  = r_txValid && arp_req_tx_ready;

    // A same-cycle match is folded in so a reply arriving on a decision cycle is never lost.
    assign w_match     = (r_state != ARP_REQ_IDLE) && arp_table_insert &&
                         (arp_table_ipv4 == r_targetIpv4);
    assign w_hitNow    = r_hit || w_match;
    assign w_hitMacNow = w_match ? arp_table_mac : r_hitMac;

    // In IDLE the target is not registered yet, so beat 0 is built from the request itself.
    assign w_buildIpv4 = (r_state == ARP_REQ_IDLE) ? req_ipv4 : r_targetIpv4;
    assign w_buildBeat = (r_state == ARP_REQ_TX0);

    micro_udp_engine_arp_req_frame #(
        .CONFIG_MAC_ADDR (CONFIG_MAC_ADDR),
        .CONFIG_IP_ADDR  (CONFIG_IP_ADDR)
    ) u_frame (
        .i_targetIpv4 (w_buildIpv4),
        .i_beat       (w_buildBeat),
        .o_data       (w_beatData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ARP_REQ_IDLE;
            r_targetIpv4  <= '0;
            r_hit         <= 1'b0;
            r_hitMac      <= '0;
            r_timer       <= '0;
            r_attempts    <= '0;
            r_txData      <= '0;
            r_txEmpty     <= '0;
            r_txSop       <= 1'b0;
            r_txEop       <= 1'b0;
            r_txValid     <= 1'b0;
            r_resolveDone <= 1'b0;
            r_resolveOk   <= 1'b0;
            r_resolveMac  <= '0;
            r_resolveIpv4 <= '0;
        end else begin
            r_resolveDone <= 1'b0;

            if (w_match) begin
                r_hit    <= 1'b1;
                r_hitMac <= arp_table_mac;
            end

            case (r_state)
                ARP_REQ_IDLE: begin
                    if (w_reqFire) begin
                        r_targetIpv4 <= req_ipv4;
                        r_hit        <= 1'b0;
                        r_hitMac     <= '0;
                        r_attempts   <= ATTEMPT_W'(1);
                        r_txData     <= w_beatData;
                        r_txEmpty    <= '0;
                        r_txSop      <= 1'b1;
                        r_txEop      <= 1'b0;
                        r_txValid    <= 1'b1;
                        r_state      <= ARP_REQ_TX0;
                    end
                end

                ARP_REQ_TX0: begin
                    if (w_beatFire) begin
                        r_txData  <= w_beatData;
                        r_txEmpty <= ARP_REQ_LAST_EMPTY;
                        r_txSop   <= 1'b0;
                        r_txEop   <= 1'b1;
                        r_state   <= ARP_REQ_TX1;
                    end
                end

                // A hit seen during the frame lets it finish, then skips the wait entirely.
                ARP_REQ_TX1: begin
                    if (w_beatFire) begin
                        r_txData  <= '0;
                        r_txEmpty <= '0;
                        r_txSop   <= 1'b0;
                        r_txEop   <= 1'b0;
                        r_txValid <= 1'b0;
                        if (w_hitNow) begin
                            r_resolveDone <= 1'b1;
                            r_resolveOk   <= 1'b1;
                            r_resolveMac  <= w_hitMacNow;
                            r_resolveIpv4 <= r_targetIpv4;
                            r_state       <= ARP_REQ_DONE;
                        end else begin
                            r_timer <= TIMER_LOAD;
                            r_state <= ARP_REQ_WAIT;
                        end
                    end
                end

                ARP_REQ_WAIT: begin
                    if (w_hitNow) begin
                        r_resolveDone <= 1'b1;
                        r_resolveOk   <= 1'b1;
                        r_resolveMac  <= w_hitMacNow;
                        r_resolveIpv4 <= r_targetIpv4;
                        r_state       <= ARP_REQ_DONE;
                    end else if (r_timer == '0) begin
                        if (r_attempts < ATTEMPT_LIMIT) begin
                            r_attempts <= r_attempts + ATTEMPT_W'(1);
                            r_txData   <= w_beatData;
                            r_txEmpty  <= '0;
                            r_txSop    <= 1'b1;
                            r_txEop    <= 1'b0;
                            r_txValid  <= 1'b1;
                            r_state    <= ARP_REQ_TX0;
                        end else begin
                            r_resolveDone <= 1'b1;
                            r_resolveOk   <= 1'b0;
                            r_resolveMac  <= '0;
                            r_resolveIpv4 <= r_targetIpv4;
                            r_state       <= ARP_REQ_DONE;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                ARP_REQ_DONE: begin
                    r_state <= ARP_REQ_IDLE;
                end

                default: begin
                    r_state <= ARP_REQ_IDLE;
                end
            endcase
        end
    end

    assign arp_req_tx_data          = r_txData;
    assign arp_req_tx_empty         = r_txEmpty;
    assign arp_req_tx_startofpacket = r_txSop;
    assign arp_req_tx_endofpacket   = r_txEop;
    assign arp_req_tx_valid         = r_txValid;

    assign resolve_done = r_resolveDone;
    assign resolve_ok   = r_resolveOk;
    assign resolve_mac  = r_resolveMac;
    assign resolve_ipv4 = r_resolveIpv4;

endmodule

// File: tb/tb_micro_udp_engine_arp_req.sv
// Self-checking bench for micro_udp_engine_arp_req: a scenario table plus randomized scenarios,
// checked against a byte-level frame model and a resolve-outcome model.
module tb_micro_udp_engine_arp_req;

    localparam logic [47:0] CFG_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] CFG_IP  = 32'h0A00_0001;
    localparam int          T       = 100;
    localparam int          MR      = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_ipv4;
    logic         arp_table_insert;
    logic [47:0]  arp_table_mac;
    logic [31:0]  arp_table_ipv4;
    logic [255:0] arp_req_tx_data;
    logic [4:0]   arp_req_tx_empty;
    logic         arp_req_tx_startofpacket;
    logic         arp_req_tx_endofpacket;
    logic         arp_req_tx_valid;
    logic         arp_req_tx_ready = 1'b1;
    logic         resolve_done;
    logic         resolve_ok;
    logic [47:0]  resolve_mac;
    logic [31:0]  resolve_ipv4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          bpMode = 0;
    int          lowLeft = 0;
    logic [31:0] curTarget = '0;
    int          scEops = 0;
    int          lastEopCycle = 0;
    int          acceptCycle = 0;
    bit          inFrame = 1'b0;
    bit          prevStall = 1'b0;
    bit          prevValid = 1'b0;
    logic [263:0] prevBeat = '0;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
        int          replyAtt;
        int          delay;
        bit          decoy;
        logic [31:0] decoyIp;
        bit          hitInTx;
        int          bp;
        bit          expOk;
        logic [47:0] expMac;
        int          expFrames;
    } vec_t;

    vec_t vecs[$];

    micro_udp_engine_arp_req #(
        .CONFIG_MAC_ADDR (CFG_MAC),
        .CONFIG_IP_ADDR  (CFG_IP),
        .TIMEOUT_CYCLES  (T),
        .MAX_RETRIES     (MR)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_ipv4                 (req_ipv4),
        .arp_table_insert         (arp_table_insert),
        .arp_table_mac            (arp_table_mac),
        .arp_table_ipv4           (arp_table_ipv4),
        .arp_req_tx_data          (arp_req_tx_data),
        .arp_req_tx_empty         (arp_req_tx_empty),
        .arp_req_tx_startofpacket (arp_req_tx_startofpacket),
        .arp_req_tx_endofpacket   (arp_req_tx_endofpacket),
        .arp_req_tx_valid         (arp_req_tx_valid),
        .arp_req_tx_ready         (arp_req_tx_ready),
        .resolve_done             (resolve_done),
        .resolve_ok               (resolve_ok),
        .resolve_mac              (resolve_mac),
        .resolve_ipv4             (resolve_ipv4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [263:0] act, input logic [263:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame model built byte by byte from the ARP request layout.
    function automatic logic [255:0] modelBeat(input logic [31:0] tpa, input int beat);
        logic [7:0]   b [64];
        logic [47:0]  mac;
        logic [31:0]  ip;
        logic [255:0] r;
        mac = CFG_MAC;
        ip  = CFG_IP;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = 8'hFF;
            b[6 + i]  = mac[47 - 8*i -: 8];
            b[22 + i] = mac[47 - 8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06;
        b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00;
        b[18] = 8'h06; b[19] = 8'h04;
        b[20] = 8'h00; b[21] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            b[28 + i] = ip[31 - 8*i -: 8];
            b[38 + i] = tpa[31 - 8*i -: 8];
        end
        r = '0;
        for (int i = 0; i < 32; i++) r[255 - 8*i -: 8] = b[32*beat + i];
        return r;
    endfunction

    // Outcome model: a reply counts if it lands inside one of the 1+MR waits (or during the frame).
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        r           = v;
        r.expOk     = v.hitInTx || (v.replyAtt >= 1 && v.replyAtt <= 1 + MR && v.delay < T);
        r.expMac    = r.expOk ? v.mac : 48'h0;
        r.expFrames = v.hitInTx ? 1 : (r.expOk ? v.replyAtt : 1 + MR);
        return r;
    endfunction

    // Ready back-pressure: 0 = always ready, 1 = random low streaks of 1..5 cycles, 2 = held low.
    always @(posedge clk) begin
        #2;
        if (bpMode == 0) begin
            arp_req_tx_ready = 1'b1;
        end else if (bpMode == 2) begin
            arp_req_tx_ready = 1'b0;
        end else if (lowLeft > 0) begin
            arp_req_tx_ready = 1'b0;
            lowLeft--;
        end else begin
            arp_req_tx_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) lowLeft = $urandom_range(1, 5);
        end
    end

    // Stream monitor: beat contents, hold-while-stalled, and frame start timing.
    always @(negedge clk) begin
        if (reset) begin
            inFrame   = 1'b0;
            prevStall = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (prevStall)
                checkOutput("hold_stable",
                    {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
                     arp_req_tx_empty, arp_req_tx_data}, prevBeat);
            if (arp_req_tx_valid && !prevValid) begin
                if (scEops == 0) checkOutput("first_valid_cycle", 264'(cyc), 264'(acceptCycle + 1));
                else             checkOutput("resend_cycle", 264'(cyc), 264'(lastEopCycle + T + 1));
            end
            if (arp_req_tx_valid && arp_req_tx_ready) begin
                if (!inFrame) begin
                    checkOutput("beat0",
                        {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
                         arp_req_tx_empty, arp_req_tx_data},
                        {1'b1, 1'b1, 1'b0, 5'd0, modelBeat(curTarget, 0)});
                    inFrame = 1'b1;
                end else begin
                    checkOutput("beat1",
                        {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
                         arp_req_tx_empty, arp_req_tx_data},
                        {1'b1, 1'b0, 1'b1, 5'd4, modelBeat(curTarget, 1)});
                    inFrame      = 1'b0;
                    scEops       = scEops + 1;
                    lastEopCycle = cyc;
                end
            end
            prevStall = arp_req_tx_valid && !arp_req_tx_ready;
            prevValid = arp_req_tx_valid;
            prevBeat  = {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
                         arp_req_tx_empty, arp_req_tx_data};
        end
    end

    task automatic applyStimulus(input vec_t v);
        int n;
        int insCycle;
        int doneCycle;
        int expDone;
        bit doneSeen;
        bpMode = v.bp;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("req_ready_idle", 264'(req_ready), 264'(1));
        curTarget   = v.ip;
        scEops      = 0;
        req_valid   = 1'b1;
        req_ipv4    = v.ip;
        acceptCycle = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("req_ready_busy", 264'(req_ready), 264'(0));

        insCycle  = -1;
        doneSeen  = 1'b0;
        doneCycle = 0;
        for (int i = 0; i < 1500 && !doneSeen; i++) begin
            arp_table_insert = 1'b0;
            if (v.hitInTx && cyc == acceptCycle + 2) begin
                arp_table_insert = 1'b1;
                arp_table_ipv4   = v.ip;
                arp_table_mac    = v.mac;
                insCycle         = cyc;
            end
            if (v.hitInTx && cyc == acceptCycle + 5) bpMode = 0;
            if (v.decoy && scEops == 1 && cyc == lastEopCycle + 1) begin
                arp_table_insert = 1'b1;
                arp_table_ipv4   = v.decoyIp;
                arp_table_mac    = 48'({$urandom(), $urandom()});
            end
            if (v.replyAtt > 0 && scEops == v.replyAtt && cyc == lastEopCycle + 1 + v.delay) begin
                arp_table_insert = 1'b1;
                arp_table_ipv4   = v.ip;
                arp_table_mac    = v.mac;
                insCycle         = cyc;
            end
            if (resolve_done) begin
                doneSeen  = 1'b1;
                doneCycle = cyc;
            end else begin
                @(posedge clk); #1;
            end
        end
        arp_table_insert = 1'b0;

        checkOutput("done_seen", 264'(doneSeen), 264'(1));
        if (doneSeen) begin
            if (!v.expOk)      expDone = lastEopCycle + T + 1;
            else if (v.hitInTx) expDone = lastEopCycle + 1;
            else               expDone = insCycle + 1;
            checkOutput("done_cycle", 264'(doneCycle), 264'(expDone));
            checkOutput("frame_count", 264'(scEops), 264'(v.expFrames));
            checkOutput("resolve_ok", 264'(resolve_ok), 264'(v.expOk));
            checkOutput("resolve_mac", 264'(resolve_mac), 264'(v.expMac));
            checkOutput("resolve_ipv4", 264'(resolve_ipv4), 264'(v.ip));
            checkOutput("ready_in_done", 264'(req_ready), 264'(0));
            @(posedge clk); #1;
            checkOutput("done_pulse_end", 264'({resolve_done, arp_req_tx_valid}), 264'(0));
            checkOutput("ready_after_done", 264'(req_ready), 264'(1));
            checkOutput("result_held", 264'({resolve_ok, resolve_mac, resolve_ipv4}),
                        264'({v.expOk, v.expMac, v.ip}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   n;
        reset            = 1'b1;
        req_valid        = 1'b0;
        req_ipv4         = '0;
        arp_table_insert = 1'b0;
        arp_table_mac    = '0;
        arp_table_ipv4   = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", 264'(req_ready), 264'(0));
        checkOutput("tx_in_reset",
            {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
             arp_req_tx_empty, arp_req_tx_data}, '0);
        checkOutput("resolve_in_reset", 264'({resolve_done, resolve_ok, resolve_mac, resolve_ipv4}), '0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", 264'(req_ready), 264'(1));
        checkOutput("tx_after_reset", 264'({arp_req_tx_valid, resolve_done}), '0);

        // ip, mac, replyAtt, delay, decoy, decoyIp, hitInTx, bp, expOk, expMac, expFrames
        vecs.push_back('{32'h0A00_0002, 48'h02_00_00_00_00_05, 1, 20, 1'b0, 32'h0, 1'b0, 0, 1'b1, 48'h02_00_00_00_00_05, 1});
        vecs.push_back('{32'h0A00_0002, 48'h02_00_00_00_00_05, 0, 0,  1'b0, 32'h0, 1'b0, 0, 1'b0, 48'h0, 3});
        vecs.push_back('{32'h0A00_0002, 48'h02_00_00_00_00_07, 1, 5,  1'b1, 32'h0A00_0009, 1'b0, 0, 1'b1, 48'h02_00_00_00_00_07, 1});
        vecs.push_back('{32'hC0A8_0164, 48'h00_11_22_33_44_55, 1, 99, 1'b0, 32'h0, 1'b0, 0, 1'b1, 48'h00_11_22_33_44_55, 1});
        vecs.push_back('{32'hC0A8_0165, 48'h00_AA_BB_CC_DD_EE, 3, 99, 1'b0, 32'h0, 1'b0, 0, 1'b1, 48'h00_AA_BB_CC_DD_EE, 3});
        vecs.push_back('{32'h0A00_0004, 48'h02_00_00_00_00_0A, 0, 0,  1'b0, 32'h0, 1'b1, 2, 1'b1, 48'h02_00_00_00_00_0A, 1});
        vecs.push_back('{32'h0A00_0006, 48'h02_00_00_00_00_0C, 2, 50, 1'b1, 32'h0A00_0016, 1'b0, 1, 1'b1, 48'h02_00_00_00_00_0C, 2});

        for (int k = 0; k < 6; k++) begin
            v.ip       = $urandom();
            v.mac      = 48'({$urandom(), $urandom()});
            v.replyAtt = $urandom_range(0, 3);
            v.delay    = $urandom_range(1, T - 1);
            v.decoy    = 1'($urandom_range(0, 1));
            v.decoyIp  = v.ip ^ 32'h0000_0100;
            v.hitInTx  = 1'b0;
            v.bp       = 1;
            vecs.push_back(predict(v));
        end

        for (int k = 0; k < vecs.size(); k++) applyStimulus(vecs[k]);

        // Reset while beat 1 is stalled, then a fresh request.
        bpMode = 0;
        @(posedge clk); #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        curTarget   = 32'h0A00_0003;
        scEops      = 0;
        req_valid   = 1'b1;
        req_ipv4    = 32'h0A00_0003;
        acceptCycle = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        bpMode = 2;
        @(posedge clk); #1;
        checkOutput("beat1_pending", 264'({arp_req_tx_valid, arp_req_tx_endofpacket}), 264'(2'b11));
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_mid_tx",
            {arp_req_tx_valid, arp_req_tx_startofpacket, arp_req_tx_endofpacket,
             arp_req_tx_empty, arp_req_tx_data}, '0);
        checkOutput("reset_mid_resolve", 264'({resolve_done, resolve_ok, resolve_mac, resolve_ipv4}), '0);
        checkOutput("reset_mid_ready", 264'(req_ready), 264'(0));
        reset  = 1'b0;
        bpMode = 0;
        @(posedge clk); #1;
        checkOutput("ready_after_mid_reset", 264'(req_ready), 264'(1));
        v = predict('{32'h0A00_0003, 48'h02_00_00_00_00_33, 1, 10, 1'b0, 32'h0, 1'b0, 0, 1'b0, 48'h0, 0});
        applyStimulus(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
